// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues in-order instruction-memory requests,
// reserves instruction-buffer slots with credits and squashes wrong-path responses.
// Optional `FETCH_PERF_EN adds push/squash performance counters.
module fetch_ctrl #(
  parameter int          IB_DEPTH  = 16,
  parameter int          MAX_OUTST = 4,
  parameter int          GH        = 8,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_i,
  input  logic          halt_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  input  logic          bp_pred_taken_i,
  input  logic [31:0]   bp_pred_target_i,
  input  logic [GH-1:0] bp_ghr_i,
  output logic          req_valid_o,
  output logic [31:0]   req_addr_o,
  input  logic          req_ready_i,
  input  logic          resp_valid_i,
  input  logic [31:0]   resp_data_i,
  output logic          ib_push_o,
  output logic [31:0]   ib_pc_o,
  output logic [31:0]   ib_inst_o,
  output logic          ib_pred_taken_o,
  output logic [31:0]   ib_pred_target_o,
  output logic [GH-1:0] ib_ghr_o,
  output logic          ib_flush_o,
  input  logic          ib_pop_i,
  output logic          busy_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetched_o,
  output logic [31:0]   perf_squashed_o
`endif
);

  localparam int CW = $clog2(IB_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int EW = 65 + GH;

  typedef enum logic [1:0] {IDLE, FETCH, HALTING, HALTED} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] credits;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [EW-1:0] mem [MAX_OUTST];

  logic          can_issue;
  logic          issue;
  logic          resp_acc;
  logic          drop;
  logic          push;
  logic [EW-1:0] head;
  logic [OW-1:0] out_after_resp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // Responses arriving with nothing outstanding are protocol errors and are ignored.
  assign can_issue      = (state == FETCH) && !halt_i && !redirect_i &&
                          (credits != '0) && (outstanding < OW'(MAX_OUTST));
  assign issue          = can_issue && req_ready_i;
  assign resp_acc       = resp_valid_i && (outstanding != '0);
  assign drop           = resp_acc && ((drop_cnt != '0) || redirect_i);
  assign push           = resp_acc && !drop;
  assign head           = mem[rd_ptr];
  assign out_after_resp = outstanding - OW'(resp_acc);

  assign req_valid_o      = can_issue;
  assign req_addr_o       = pc;
  assign ib_push_o        = push;
  assign ib_pc_o          = push ? head[EW-1 -: 32] : '0;
  assign ib_pred_taken_o  = push && head[GH+32];
  assign ib_pred_target_o = push ? head[GH+31:GH] : '0;
  assign ib_ghr_o         = push ? head[GH-1:0] : '0;
  assign ib_inst_o        = push ? resp_data_i : '0;
  assign ib_flush_o       = redirect_i && reset;
  assign busy_o           = (outstanding != '0);

  // Snapshot storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (issue) begin
      mem[wr_ptr] <= {pc, bp_pred_taken_i, bp_pred_target_i, bp_ghr_i};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      credits     <= CW'(IB_DEPTH);
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (redirect_i) begin
        // Every request still in flight after this cycle belongs to the wrong path.
        pc          <= redirect_pc_i;
        credits     <= CW'(IB_DEPTH);
        outstanding <= out_after_resp;
        drop_cnt    <= out_after_resp;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        outstanding <= out_after_resp + OW'(issue);
        if (drop) begin
          drop_cnt <= drop_cnt - OW'(1);
        end
        if (push) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (issue) begin
          wr_ptr <= ptr_inc(wr_ptr);
          pc     <= bp_pred_taken_i ? bp_pred_target_i : pc + 32'd4;
        end
        if (issue && !ib_pop_i) begin
          credits <= credits - CW'(1);
        end else if (!issue && ib_pop_i && (credits < CW'(IB_DEPTH))) begin
          credits <= credits + CW'(1);
        end
      end

      case (state)
        IDLE:    if (start_i) state <= FETCH;
        FETCH:   if (halt_i) state <= HALTING;
        HALTING: begin
          if (start_i && !halt_i) state <= FETCH;
          else if (out_after_resp == '0) state <= HALTED;
        end
        HALTED:  if (start_i && !halt_i) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Counters survive redirects so they measure whole-run fetch efficiency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_o  <= '0;
      perf_squashed_o <= '0;
    end else begin
      if (push) perf_fetched_o <= perf_fetched_o + 32'd1;
      if (drop) perf_squashed_o <= perf_squashed_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of in-flight requests and buffer occupancy.
module tb_fetch_ctrl;

  localparam int          IB_DEPTH  = 4;
  localparam int          MAX_OUTST = 4;
  localparam int          GH        = 8;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_i, halt_i, redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          bp_pred_taken_i;
  logic [31:0]   bp_pred_target_i;
  logic [GH-1:0] bp_ghr_i;
  logic          req_valid_o;
  logic [31:0]   req_addr_o;
  logic          req_ready_i, resp_valid_i;
  logic [31:0]   resp_data_i;
  logic          ib_push_o;
  logic [31:0]   ib_pc_o, ib_inst_o, ib_pred_target_o;
  logic          ib_pred_taken_o;
  logic [GH-1:0] ib_ghr_o;
  logic          ib_flush_o, ib_pop_i, busy_o;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched_o, perf_squashed_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0]   pc;
    logic          taken;
    logic [31:0]   target;
    logic [GH-1:0] ghr;
    bit            squashed;
  } req_t;

  req_t        inflight[$];
  int          occ;
  logic [31:0] m_pc;
  int          mode;
  int          m_fetched, m_squashed;

  fetch_ctrl #(.IB_DEPTH(IB_DEPTH), .MAX_OUTST(MAX_OUTST), .GH(GH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .halt_i(halt_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .bp_pred_taken_i(bp_pred_taken_i), .bp_pred_target_i(bp_pred_target_i), .bp_ghr_i(bp_ghr_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
    .ib_push_o(ib_push_o), .ib_pc_o(ib_pc_o), .ib_inst_o(ib_inst_o),
    .ib_pred_taken_o(ib_pred_taken_o), .ib_pred_target_o(ib_pred_target_o), .ib_ghr_o(ib_ghr_o),
    .ib_flush_o(ib_flush_o), .ib_pop_i(ib_pop_i), .busy_o(busy_o)
`ifdef FETCH_PERF_EN
    , .perf_fetched_o(perf_fetched_o), .perf_squashed_o(perf_squashed_o)
`endif
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    start_i = 1'b0; halt_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    bp_pred_taken_i = 1'b0; bp_pred_target_i = '0; bp_ghr_i = '0;
    req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0; ib_pop_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic do_reset();
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b1;
  endtask

  // Reset and start at the current negedge; returns once the fetch state is active.
  task automatic reset_and_start();
    do_reset();
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    start_i = 1'b1;
    resp_valid_i = 1'b1;
    resp_data_i = 32'hDEADBEEF;
    #1;
    vectors++;
    if (req_valid_o !== 1'b0 || req_addr_o !== RESET_PC || ib_push_o !== 1'b0 ||
        busy_o !== 1'b0 || ib_inst_o !== 32'h0 || ib_pc_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: valid=%b addr=%h push=%b busy=%b inst=%h pc=%h, expected 0/%h/0/0/0/0",
               req_valid_o, req_addr_o, ib_push_o, busy_o, ib_inst_o, ib_pc_o, RESET_PC);
    end
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    #1;
    vectors++;
    if (req_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: req_valid=%b, expected 0", req_valid_o);
    end
  endtask

  task automatic test_credit_limit();
    reset_and_start();
    req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (req_valid_o !== 1'b1 || req_addr_o !== 32'(i * 4)) begin
        miscompares++;
        $display("[TB] FAIL credit_issue%0d: valid=%b addr=%h, expected 1/%h", i, req_valid_o, req_addr_o, 32'(i * 4));
      end
      next_cycle();
    end
    #1;
    vectors++;
    if (req_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL credit_stall: req_valid=%b, expected 0", req_valid_o);
    end
    for (int i = 0; i < 2; i++) begin
      resp_valid_i = 1'b1;
      resp_data_i = 32'hAAAA0001 + 32'(i);
      #1;
      vectors++;
      if (ib_push_o !== 1'b1 || ib_pc_o !== 32'(i * 4) || ib_inst_o !== 32'hAAAA0001 + 32'(i) || req_valid_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL credit_resp%0d: push=%b pc=%h inst=%h valid=%b, expected 1/%h/%h/0",
                 i, ib_push_o, ib_pc_o, ib_inst_o, req_valid_o, 32'(i * 4), 32'hAAAA0001 + 32'(i));
      end
      next_cycle();
    end
    resp_valid_i = 1'b0;
    ib_pop_i = 1'b1;
    next_cycle();
    ib_pop_i = 1'b0;
    #1;
    vectors++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 32'h10) begin
      miscompares++;
      $display("[TB] FAIL credit_after_pop: valid=%b addr=%h, expected 1/00000010", req_valid_o, req_addr_o);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_branch_pred();
    reset_and_start();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    vectors++;
    if (ib_flush_o !== 1'b1 || req_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_redirect: flush=%b valid=%b, expected 1/0", ib_flush_o, req_valid_o);
    end
    next_cycle();
    redirect_i = 1'b0;
    req_ready_i = 1'b1;
    bp_pred_taken_i = 1'b1;
    bp_pred_target_i = 32'h200;
    bp_ghr_i = 8'h5A;
    #1;
    vectors++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 32'h100) begin
      miscompares++;
      $display("[TB] FAIL bp_issue: valid=%b addr=%h, expected 1/00000100", req_valid_o, req_addr_o);
    end
    next_cycle();
    bp_pred_taken_i = 1'b0;
    bp_pred_target_i = '0;
    bp_ghr_i = '0;
    req_ready_i = 1'b0;
    resp_valid_i = 1'b1;
    resp_data_i = 32'h13579BDF;
    #1;
    vectors++;
    if (req_addr_o !== 32'h200 || ib_push_o !== 1'b1 || ib_pc_o !== 32'h100 || ib_pred_taken_o !== 1'b1 ||
        ib_pred_target_o !== 32'h200 || ib_ghr_o !== 8'h5A || ib_inst_o !== 32'h13579BDF) begin
      miscompares++;
      $display("[TB] FAIL bp_push: addr=%h push=%b pc=%h taken=%b target=%h ghr=%h inst=%h, expected 200/1/100/1/200/5a/13579bdf",
               req_addr_o, ib_push_o, ib_pc_o, ib_pred_taken_o, ib_pred_target_o, ib_ghr_o, ib_inst_o);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_redirect_squash();
    reset_and_start();
    req_ready_i = 1'b1;
    repeat (2) next_cycle();
    req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h400;
    #1;
    vectors++;
    if (ib_flush_o !== 1'b1 || busy_o !== 1'b1 || req_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL redir_flush: flush=%b busy=%b valid=%b, expected 1/1/0", ib_flush_o, busy_o, req_valid_o);
    end
    next_cycle();
    redirect_i = 1'b0;
    req_ready_i = 1'b1;
    #1;
    vectors++;
    if (ib_flush_o !== 1'b0 || req_valid_o !== 1'b1 || req_addr_o !== 32'h400) begin
      miscompares++;
      $display("[TB] FAIL redir_issue: flush=%b valid=%b addr=%h, expected 0/1/00000400", ib_flush_o, req_valid_o, req_addr_o);
    end
    next_cycle();
    req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resp_valid_i = 1'b1;
      resp_data_i = $urandom;
      #1;
      vectors++;
      if (ib_push_o !== (k == 2) || (k == 2 && ib_pc_o !== 32'h400)) begin
        miscompares++;
        $display("[TB] FAIL redir_resp%0d: push=%b pc=%h, expected %0d/00000400", k, ib_push_o, ib_pc_o, (k == 2));
      end
      next_cycle();
    end
    resp_valid_i = 1'b0;
    req_ready_i = 1'b1;
    // One entry sits in the buffer, so exactly three more credits must remain.
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (req_valid_o !== (k < 3) || (k < 3 && req_addr_o !== 32'h404 + 32'(4 * k))) begin
        miscompares++;
        $display("[TB] FAIL redir_credit%0d: valid=%b addr=%h, expected %0d/%h", k, req_valid_o, req_addr_o, (k < 3), 32'h404 + 32'(4 * k));
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_halt();
    reset_and_start();
    req_ready_i = 1'b1;
    repeat (3) next_cycle();
    halt_i = 1'b1;
    #1;
    vectors++;
    if (req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL halt_stop: valid=%b busy=%b, expected 0/1", req_valid_o, busy_o);
    end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      resp_valid_i = 1'b1;
      resp_data_i = 32'hBBBB0000 + 32'(k);
      #1;
      vectors++;
      if (ib_push_o !== 1'b1 || ib_pc_o !== 32'(4 * k) || ib_inst_o !== 32'hBBBB0000 + 32'(k) || req_valid_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL halt_resp%0d: push=%b pc=%h inst=%h valid=%b, expected 1/%h/%h/0",
                 k, ib_push_o, ib_pc_o, ib_inst_o, req_valid_o, 32'(4 * k), 32'hBBBB0000 + 32'(k));
      end
      next_cycle();
    end
    resp_valid_i = 1'b0;
    #1;
    vectors++;
    if (busy_o !== 1'b0 || req_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL halt_idle: busy=%b valid=%b, expected 0/0", busy_o, req_valid_o);
    end
    repeat (2) next_cycle();
    halt_i = 1'b0;
    start_i = 1'b1;
    #1;
    vectors++;
    if (req_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL halt_start_cycle: valid=%b, expected 0", req_valid_o);
    end
    next_cycle();
    start_i = 1'b0;
    #1;
    vectors++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 32'hC) begin
      miscompares++;
      $display("[TB] FAIL halt_resume: valid=%b addr=%h, expected 1/0000000c", req_valid_o, req_addr_o);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_midrun();
    reset_and_start();
    req_ready_i = 1'b1;
    repeat (2) next_cycle();
    req_ready_i = 1'b0;
    resp_valid_i = 1'b1;
    resp_data_i = 32'hCCCC0000;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (busy_o !== 1'b0 || req_valid_o !== 1'b0 || ib_push_o !== 1'b0 || req_addr_o !== RESET_PC) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset: busy=%b valid=%b push=%b addr=%h, expected 0/0/0/%h",
               busy_o, req_valid_o, ib_push_o, req_addr_o, RESET_PC);
    end
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    req_ready_i = 1'b1;
    #1;
    vectors++;
    if (req_valid_o !== 1'b1 || req_addr_o !== RESET_PC) begin
      miscompares++;
      $display("[TB] FAIL midrun_restart: valid=%b addr=%h, expected 1/%h", req_valid_o, req_addr_o, RESET_PC);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random_traffic();
    int   live, credits;
    bit   exp_valid, acc, exp_push;
    req_t e;
    do_reset();
    inflight.delete();
    occ = 0; m_pc = RESET_PC; mode = 0; m_fetched = 0; m_squashed = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      start_i          = ($urandom_range(9) == 0);
      if ($urandom_range(19) == 0) halt_i = ~halt_i;
      redirect_i       = ($urandom_range(24) == 0);
      redirect_pc_i    = $urandom & 32'hFFFF_FFFC;
      bp_pred_taken_i  = ($urandom_range(3) == 0);
      bp_pred_target_i = $urandom & 32'h0000_FFFC;
      bp_ghr_i         = GH'($urandom);
      req_ready_i      = ($urandom_range(3) != 0);
      resp_valid_i     = (inflight.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      resp_data_i      = $urandom;
      ib_pop_i         = (occ > 0) && ($urandom_range(2) == 0);
      #1;
      live = 0;
      foreach (inflight[i]) if (!inflight[i].squashed) live++;
      credits   = IB_DEPTH - occ - live;
      exp_valid = (mode == 1) && !halt_i && !redirect_i && credits > 0 && inflight.size() < MAX_OUTST;
      acc       = resp_valid_i && inflight.size() > 0;
      exp_push  = acc && !inflight[0].squashed && !redirect_i;

      vectors++;
      if (req_valid_o !== exp_valid || (exp_valid && req_addr_o !== m_pc)) begin
        miscompares++;
        $display("[TB] FAIL rand_req cyc%0d: valid=%b addr=%h, expected %b/%h", cyc, req_valid_o, req_addr_o, exp_valid, m_pc);
      end
      vectors++;
      if (ib_push_o !== exp_push) begin
        miscompares++;
        $display("[TB] FAIL rand_push cyc%0d: push=%b, expected %b", cyc, ib_push_o, exp_push);
      end
      if (exp_push) begin
        vectors++;
        if (ib_pc_o !== inflight[0].pc || ib_inst_o !== resp_data_i || ib_pred_taken_o !== inflight[0].taken ||
            ib_pred_target_o !== inflight[0].target || ib_ghr_o !== inflight[0].ghr) begin
          miscompares++;
          $display("[TB] FAIL rand_entry cyc%0d: pc=%h inst=%h taken=%b target=%h ghr=%h, expected %h/%h/%b/%h/%h",
                   cyc, ib_pc_o, ib_inst_o, ib_pred_taken_o, ib_pred_target_o, ib_ghr_o,
                   inflight[0].pc, resp_data_i, inflight[0].taken, inflight[0].target, inflight[0].ghr);
        end
      end
      vectors++;
      if (ib_flush_o !== redirect_i || busy_o !== (inflight.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL rand_flush_busy cyc%0d: flush=%b busy=%b, expected %b/%b",
                 cyc, ib_flush_o, busy_o, redirect_i, (inflight.size() != 0));
      end

      if (acc) begin
        e = inflight.pop_front();
        if (e.squashed || redirect_i) m_squashed++;
        else begin occ++; m_fetched++; end
      end
      if (ib_pop_i && !redirect_i) occ--;
      if (redirect_i) begin
        foreach (inflight[i]) inflight[i].squashed = 1'b1;
        occ  = 0;
        m_pc = redirect_pc_i;
      end else if (exp_valid && req_ready_i) begin
        inflight.push_back('{m_pc, bp_pred_taken_i, bp_pred_target_i, bp_ghr_i, 1'b0});
        m_pc = bp_pred_taken_i ? bp_pred_target_i : m_pc + 32'd4;
      end
      if (mode == 0 && start_i) mode = 1;
      else if (mode == 1 && halt_i) mode = 2;
      else if (mode == 2 && start_i && !halt_i) mode = 1;
      next_cycle();
    end
`ifdef FETCH_PERF_EN
    #1;
    vectors++;
    if (perf_fetched_o !== 32'(m_fetched) || perf_squashed_o !== 32'(m_squashed)) begin
      miscompares++;
      $display("[TB] FAIL rand_perf: fetched=%0d squashed=%0d, expected %0d/%0d",
               perf_fetched_o, perf_squashed_o, m_fetched, m_squashed);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_credit_limit();
    test_branch_pred();
    test_redirect_squash();
    test_halt();
    test_reset_midrun();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer that owns the fetch PC and issues in-order instruction-memory requests. It writes returning instructions, with their branch-prediction metadata, into the instruction buffer. It reserves buffer slots with a credit counter, so the buffer never sees a push while full. On redirect it flushes the buffer and squashes in-flight responses, so only correct-path instructions are pushed.

Parameters:
IB_DEPTH, 16, instruction-buffer capacity; initial credit count
MAX_OUTST, 4, maximum in-flight memory requests (power of 2)
GH, 8, global-history snapshot width
RESET_PC, 32'h0, fetch PC loaded at reset

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-low reset (asserted at 0)
start_i  input  1  one-cycle pulse; leaves IDLE/HALTED to FETCH
halt_i  input  1  level; stop issuing new requests
redirect_i  input  1  mispredict/exception redirect
redirect_pc_i  input  32  new fetch PC
bp_pred_taken_i  input  1  predictor result for current req_addr_o (combinational)
bp_pred_target_i  input  32  predicted target
bp_ghr_i  input  GH  GHR snapshot for current PC
req_valid_o  output  1  memory request valid
req_addr_o  output  32  request address (= fetch PC)
req_ready_i  input  1  memory accepts request
resp_valid_i  input  1  in-order response valid (always accepted)
resp_data_i  input  32  instruction word
ib_push_o  output  1  push to instruction buffer
ib_pc_o  output  32  pushed PC
ib_inst_o  output  32  pushed instruction
ib_pred_taken_o  output  1  pushed prediction
ib_pred_target_o  output  32  pushed target
ib_ghr_o  output  GH  pushed GHR snapshot
ib_flush_o  output  1  buffer flush (= redirect_i, combinational)
ib_pop_i  input  1  decode consumed a buffer entry (pop && !empty)
busy_o  output  1  outstanding != 0

Behaviour:
- Reset (async, reset==0):
  - state = IDLE, pc = RESET_PC, credits = IB_DEPTH, outstanding = 0, drop_cnt = 0, in-flight FIFO empty.
  - All outputs are 0 except req_addr_o = RESET_PC.
  - Reset mid-operation discards all in-flight state immediately.
- States: IDLE, FETCH, HALTING, HALTED.
  - IDLE -> FETCH on start_i.
  - FETCH -> HALTING on halt_i.
  - HALTING -> HALTED when outstanding == 0 (in the same cycle if already 0).
  - HALTING/HALTED -> FETCH on start_i with halt_i == 0.
- Issue:
  - req_valid_o = (state == FETCH) && !halt_i && !redirect_i && credits > 0 && outstanding < MAX_OUTST.
  - req_addr_o = pc.
  - On req_valid_o && req_ready_i:
    - push {pc, bp_pred_taken_i, bp_pred_target_i, bp_ghr_i} into the in-flight FIFO (depth MAX_OUTST)
    - pc <= bp_pred_taken_i ? bp_pred_target_i : pc + 4 (mod 2^32)
    - credits -1, outstanding +1
- Response, with resp_valid_i:
  - If drop_cnt > 0 or redirect_i: discard; decrement drop_cnt if it was > 0; no push.
  - Otherwise: ib_push_o = 1 in the same cycle (zero latency), ib_inst_o = resp_data_i, metadata from FIFO head; pop the FIFO.
  - Every accepted response decrements outstanding.
- Credits:
  - +1 on each ib_pop_i, except in a redirect cycle.
  - Issue and pop in the same cycle: net 0.
  - credits never exceeds IB_DEPTH; invariant credits + buffer occupancy + live in-flight = IB_DEPTH.
- Redirect (any state):
  - pc <= redirect_pc_i; in-flight FIFO cleared; credits <= IB_DEPTH.
  - drop_cnt <= outstanding after this cycle's response accounting (no issue happens in a redirect cycle).
  - ib_flush_o = 1; state unchanged.
- A response arriving with no request outstanding is a protocol error; it is ignored (no push, counters unchanged).

Optional Feature:
FETCH_PERF_EN: adds outputs perf_fetched_o[31:0] (count of pushes) and perf_squashed_o[31:0] (count of dropped responses). Both are 32-bit wrapping counters, zeroed by reset and not cleared by redirect. Without the macro these ports and counters do not exist.

Test Plan:
- IB_DEPTH=4, MAX_OUTST=4, req_ready_i=1, no pops, start at PC 0 -> four requests issued at addresses 0x0, 0x4, 0x8, 0xC. req_valid_o stays 0 after the fourth; one ib_pop_i then allows a fifth request at 0x10.
- Responses 0xAAAA0001 and 0xAAAA0002 return for requests 0x0 and 0x4 -> ib_push_o on each response cycle with ib_pc_o = 0x0, then 0x4, and matching ib_inst_o.
- At PC 0x100, bp_pred_taken_i=1 and bp_pred_target_i=0x200 -> next req_addr_o = 0x200; the pushed entry for 0x100 carries ib_pred_taken_o=1 and ib_pred_target_o=0x200.
- 2 requests outstanding, redirect_i with redirect_pc_i=0x400 -> ib_flush_o=1 for one cycle and the next 2 responses are dropped. The next request goes to 0x400, its response pushes with ib_pc_o=0x400, and credits return to IB_DEPTH.
- halt_i asserted with 3 requests outstanding -> no new requests, all 3 responses are pushed, state reaches HALTED, busy_o=0. start_i resumes fetch at the next sequential PC.
- reset driven to 0 mid-run with 2 requests outstanding -> outputs clear asynchronously; after release, start_i makes the first request go to RESET_PC.
